// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: controller states,
// PC redirect encodings and write-enable / flush levels.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    WAIT_DS  = 2'd2
  } pipe_ctrl_state_e;

  localparam logic [1:0] REDIR_SEQ = 2'd0;
  localparam logic [1:0] REDIR_BR  = 2'd1;
  localparam logic [1:0] REDIR_EXC = 2'd2;

  localparam logic WR_EN     = 1'b1;
  localparam logic WR_HOLD   = 1'b0;
  localparam logic FLUSH_ON  = 1'b1;
  localparam logic FLUSH_OFF = 1'b0;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Loadable down-counter timing the multi-cycle mult/div occupancy of EXE.
module pipe_mdu_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. Optional performance
// counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = $clog2(MDU_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ICache_Busy,
  input  logic       DCache_Busy,
  input  logic       EXE_IsLoad,
  input  logic [4:0] EXE_rt,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_Valid,
  input  logic       EXE_MduStart,
  input  logic       EXE_BranchTaken,
  input  logic       MEM_ExceptValid,
  output logic       PC_Wr,
  output logic       ID_Wr,
  output logic       EXE_Wr,
  output logic       MEM_Wr,
  output logic       WB_Wr,
  output logic       ID_Flush,
  output logic       EXE_Flush,
  output logic       MEM_Flush,
  output logic       WB_Flush,
  output logic [1:0] Redirect_Sel,
  output logic       Busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] Perf_StallCyc,
  output logic [31:0] Perf_FlushCyc
`endif
);

  pipe_ctrl_state_e state_q, state_d;

  logic             cnt_load, cnt_dec, cnt_done;
  logic [CNT_W-1:0] cnt_load_val;
  logic             pc_wr, id_wr, exe_wr, mem_wr, wb_wr;
  logic             id_fl, exe_fl, mem_fl, wb_fl;
  logic [1:0]       redir;
  logic             exc_taken, br_squash, load_use;

  assign load_use = EXE_IsLoad && (EXE_rt != 5'd0) &&
                    ((EXE_rt == ID_rs) || (EXE_rt == ID_rt));

  pipe_mdu_timer #(.CNT_W(CNT_W)) u_mdu_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    pc_wr = WR_EN;  id_wr = WR_EN;  exe_wr = WR_EN;  mem_wr = WR_EN;  wb_wr = WR_EN;
    id_fl = FLUSH_OFF; exe_fl = FLUSH_OFF; mem_fl = FLUSH_OFF; wb_fl = FLUSH_OFF;
    redir     = REDIR_SEQ;
    exc_taken = 1'b0;
    br_squash = 1'b0;

    if (DCache_Busy) begin
      // Freeze everything up to MEM; pending exception/branch are re-seen next cycle.
      pc_wr = WR_HOLD; id_wr = WR_HOLD; exe_wr = WR_HOLD; mem_wr = WR_HOLD;
      wb_fl = FLUSH_ON;
    end else if (MEM_ExceptValid) begin
      id_fl = FLUSH_ON; exe_fl = FLUSH_ON; mem_fl = FLUSH_ON; wb_fl = FLUSH_ON;
      redir        = REDIR_EXC;
      state_d      = RUN;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
      exc_taken    = 1'b1;
    end else begin
      unique case (state_q)
        MDU_WAIT: begin
          if (!cnt_done) begin
            pc_wr = WR_HOLD; id_wr = WR_HOLD; exe_wr = WR_HOLD;
            mem_fl  = FLUSH_ON;
            cnt_dec = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        WAIT_DS: begin
          // ID already holds a bubble; keep it out of EXE until the delay slot arrives.
          exe_fl = FLUSH_ON;
          if (ICache_Busy) begin
            pc_wr = WR_HOLD; id_wr = WR_HOLD;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          if (EXE_MduStart) begin
            pc_wr = WR_HOLD; id_wr = WR_HOLD; exe_wr = WR_HOLD;
            mem_fl       = FLUSH_ON;
            state_d      = MDU_WAIT;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(MDU_CYCLES - 2);
          end else if (EXE_BranchTaken) begin
            redir = REDIR_BR;
            if (ID_Valid) begin
              id_fl     = FLUSH_ON;
              br_squash = 1'b1;
            end else begin
              state_d = WAIT_DS;
            end
          end else if (load_use) begin
            pc_wr = WR_HOLD; id_wr = WR_HOLD;
            exe_fl = FLUSH_ON;
          end else if (ICache_Busy) begin
            pc_wr = WR_HOLD;
            id_fl = FLUSH_ON;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Reset overrides the decoded controls so the pipeline registers clear immediately.
  always_comb begin
    if (!rst) begin
      {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr}   = {5{WR_HOLD}};
      {ID_Flush, EXE_Flush, MEM_Flush, WB_Flush} = {4{FLUSH_ON}};
      Redirect_Sel = REDIR_SEQ;
      Busy         = 1'b0;
    end else begin
      {PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr}   = {pc_wr, id_wr, exe_wr, mem_wr, wb_wr};
      {ID_Flush, EXE_Flush, MEM_Flush, WB_Flush} = {id_fl, exe_fl, mem_fl, wb_fl};
      Redirect_Sel = redir;
      Busy         = (state_q != RUN);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cyc_q, stall_cyc_d, flush_cyc_q, flush_cyc_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q + {31'd0, (!pc_wr || !id_wr)};
    flush_cyc_d = flush_cyc_q + {31'd0, (exc_taken || br_squash)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_q <= '0;
      flush_cyc_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cyc_q <= flush_cyc_d;
    end
  end

  assign Perf_StallCyc = stall_cyc_q;
  assign Perf_FlushCyc = flush_cyc_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF→ID→EXE→MEM→WB).
- Generates the per-stage write-enable and flush strobes consumed by the pipeline registers, including ID_Wr/ID_Flush for the IF/ID register.
- Sequences load-use stalls, multi-cycle MDU waits, D-cache/I-cache stalls, taken-branch wrong-path squash (with MIPS delay-slot handling) and exception flushes.
- Sits beside the datapath. Outputs are combinational from current state and inputs. A small FSM and counter hold the multi-cycle conditions.

Parameters:
- MDU_CYCLES, 32: EXE-stage cycles a mult/div occupies (≥2).
- CNT_W, $clog2(MDU_CYCLES): MDU down-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- ICache_Busy  in  1  IF cannot deliver an instruction this cycle
- DCache_Busy  in  1  MEM access outstanding
- EXE_IsLoad  in  1  EXE holds a load
- EXE_rt  in  5  load destination register
- ID_rs, ID_rt  in  5 each  ID source registers
- ID_Valid  in  1  ID holds a real instruction (not a bubble)
- EXE_MduStart  in  1  EXE holds a mult/div, first cycle
- EXE_BranchTaken  in  1  branch/jump in EXE resolved taken
- MEM_ExceptValid  in  1  exception detected in MEM
- PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr  out  1 each  stage register load enable
- ID_Flush, EXE_Flush, MEM_Flush, WB_Flush  out  1 each  clear register to bubble on next edge
- Redirect_Sel  out  2  PC source: 0 seq, 1 branch target, 2 exception vector
- Busy  out  1  state ≠ RUN

Behaviour:
- Reset (rst=0, async): state←RUN, cnt←0. While rst=0, all *_Wr=0, all *_Flush=1, Redirect_Sel=0, Busy=0.
- States: RUN, MDU_WAIT, WAIT_DS.
- Default in RUN with no event: all Wr=1, all Flush=0, Redirect_Sel=0.
- Priority per cycle, highest first: DCache_Busy > MEM_ExceptValid > MDU > branch > load-use > ICache_Busy.
- DCache_Busy, any state:
  - PC/ID/EXE/MEM_Wr=0; WB_Flush=1.
  - State and cnt frozen; exception and branch are not acted on and are resampled next cycle.
- MEM_ExceptValid, not DCache_Busy:
  - ID/EXE/MEM/WB_Flush=1; PC_Wr=1; Redirect_Sel=2.
  - Next state RUN, cnt←0. This aborts MDU_WAIT and WAIT_DS.
- MDU:
  - In RUN, EXE_MduStart=1 → next MDU_WAIT, cnt←MDU_CYCLES-2. The start cycle itself stalls PC/ID/EXE (Wr=0) with MEM_Flush=1.
  - In MDU_WAIT, cnt≠0: same stall, cnt decrements.
  - In MDU_WAIT, cnt=0: all Wr=1, next RUN.
  - Total EXE occupancy is exactly MDU_CYCLES cycles.
- Branch, RUN, EXE_BranchTaken=1:
  - If ID_Valid=1 (delay slot already in ID): PC_Wr=1, Redirect_Sel=1, ID_Flush=1 to squash the wrong-path IF instruction.
  - If ID_Valid=0: PC_Wr=1, Redirect_Sel=1, no flush; next WAIT_DS.
  - In WAIT_DS: ID_Flush=0. The first cycle with ICache_Busy=0 lets the delay slot enter ID, then → RUN. EXE_Flush=1 while waiting so no instruction is duplicated in EXE.
- Load-use: EXE_IsLoad && EXE_rt≠0 && (EXE_rt==ID_rs || EXE_rt==ID_rt) → PC_Wr=0, ID_Wr=0, EXE_Flush=1. Lasts one cycle unless a higher-priority event occurs.
- ICache_Busy, RUN, no other event: PC_Wr=0, ID_Flush=1; EXE/MEM/WB continue.
- Flush always dominates Wr on the same register.
- Busy=1 in MDU_WAIT and WAIT_DS.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- When defined: add outputs Perf_StallCyc[31:0] and Perf_FlushCyc[31:0].
  - Perf_StallCyc increments every cycle in which any of PC_Wr or ID_Wr is 0 while rst=1.
  - Perf_FlushCyc increments on each exception or branch-squash cycle.
  - Both wrap at 2^32 and reset to 0.
- When undefined: no counters and no extra ports; the remaining logic is identical.

Decomposition:
- Shared package (CPU defines):
  - enum PipeCtrlState {RUN, MDU_WAIT, WAIT_DS}.
  - Redirect_Sel encodings as localparams: REDIR_SEQ=0, REDIR_BR=1, REDIR_EXC=2.
  - Flush/Wr enable-level constants.
- One sub-module, pipe_mdu_timer: loadable down-counter with a done flag, instantiated once.

Test Plan:
- Reset: pulse rst=0 mid-MDU_WAIT (cnt=17) → immediately all Wr=0, all Flush=1. After release, state=RUN, all Wr=1.
- Load-use: EXE_IsLoad=1, EXE_rt=5, ID_rs=5 → one cycle PC_Wr=ID_Wr=0, EXE_Flush=1. With EXE_rt=0 → no stall.
- MDU: MDU_CYCLES=32, EXE_MduStart pulse → PC/ID/EXE_Wr=0 for exactly 31 cycles, then 1. Busy=1 for 31 cycles.
- Branch, delay-slot case:
  - EXE_BranchTaken=1 with ID_Valid=1 → Redirect_Sel=1, ID_Flush=1.
  - EXE_BranchTaken=1 with ID_Valid=0 and ICache_Busy=1 for 3 cycles → WAIT_DS held 3 cycles, ID_Flush=0, then RUN.
- Simultaneous events:
  - MEM_ExceptValid + EXE_BranchTaken + load-use → Redirect_Sel=2, ID/EXE/MEM/WB_Flush=1.
  - Same with DCache_Busy=1 → full freeze and WB_Flush=1; exception taken the first cycle DCache_Busy falls.
- PIPE_PERF_CNT_EN: 10 load-use stalls + 2 exceptions → Perf_StallCyc=10, Perf_FlushCyc=2.
